seq_divider: RTL

Iterative unsigned divider. It is the inverse companion of the running-sum accumulator: it unwinds a total by restoring shift-and-subtract, one quotient bit per clock. It sits beside the accumulator in the datapath. Operands are captured on a start strobe, and quotient/remainder are returned with a one-cycle done pulse. Results are held until the next accepted start.

---
 rtl/seq_divider.sv | 94 +++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, WIDTH+1 edges from start to done.
// Divide-by-zero finishes right away with all-ones quotient and the dividend as remainder.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   r_reg;

  logic             accept;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   r_next;

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign accept = start && (state != S_RUN);

  // Compare is one bit wider than the operands so a divisor with its MSB set cannot lose the carry.
  assign trial  = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign diff   = trial - {1'b0, d_reg};
  assign ge     = (trial >= {1'b0, d_reg});
  assign q_next = {q_reg[WIDTH-2:0], ge};
  assign r_next = ge ? diff : trial;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      d_reg       <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          if (cnt == '0) begin
            state       <= S_DONE;
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start; DONE otherwise falls back to IDLE.
          if (accept) begin
            d_reg <= divisor;
            q_reg <= dividend;
            r_reg <= '0;
            cnt   <= CNT_W'(WIDTH - 1);
            if (divisor == '0) begin
              state       <= S_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
